// File: rtl/gpr_scoreboard_bank.sv
// Parametrised register bank with busy-bit scoreboard, write-to-read bypass and flush.
// One bank instance serves one register group (integer, float or matrix).

module gpr_scoreboard_rdport #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int IDX_W    = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [IDX_W-1:0]             i_idx,
  input  logic [DEPTH-1:0][DATA_W-1:0] i_regs,
  input  logic [DEPTH-1:0]             i_busy,
  input  logic                         i_wr_eff,
  input  logic [IDX_W-1:0]             i_wr_idx,
  input  logic [DATA_W-1:0]            i_wr_data,
  output logic [DATA_W-1:0]            o_data,
  output logic                         o_busy
);
  always_comb begin
    o_data = i_regs[i_idx];
    o_busy = i_busy[i_idx];
    if (ZERO_REG != 0 && i_idx == '0) begin
      o_data = '0;
      o_busy = 1'b0;
    end else if (BYPASS != 0 && i_wr_eff && i_wr_idx == i_idx) begin
      // the register is being written this cycle: forward and report ready
      o_data = i_wr_data;
      o_busy = 1'b0;
    end
  end
endmodule

module gpr_scoreboard_bank #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int IDX_W    = $clog2(DEPTH),
  parameter int NRD      = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_valid,
  input  logic [IDX_W-1:0]           alloc_idx,
  output logic                       alloc_ready,
  input  logic                       we,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       flush,
  input  logic [NRD*IDX_W-1:0]       rd_idx,
  output logic [NRD*DATA_W-1:0]      rd_data,
  output logic [NRD-1:0]             rd_busy,
  output logic [$clog2(DEPTH+1)-1:0] busy_cnt,
  output logic                       err_wr_idle
);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0][DATA_W-1:0] r_regs;
  logic [DEPTH-1:0]             r_busy;
  logic [CNT_W-1:0]             r_cnt;
  logic                         r_err;

  logic             w_wr_eff;
  logic             w_alloc_zero;
  logic             w_alloc_fire;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_wr_eff     = we && !(ZERO_REG != 0 && wr_idx == '0);
  assign w_alloc_zero = (ZERO_REG != 0) && (alloc_idx == '0);

  // A busy destination may be re-allocated only when its write-back lands this cycle
  always_comb begin
    alloc_ready = 1'b0;
    if (!flush)
      alloc_ready = w_alloc_zero || !r_busy[alloc_idx] ||
                    (w_wr_eff && wr_idx == alloc_idx);
  end

  assign w_alloc_fire = alloc_valid && alloc_ready && !w_alloc_zero;

  // Allocation is applied after the write clear so a same-index pair stays busy
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_eff)     w_busy_nxt[wr_idx]    = 1'b0;
    if (w_alloc_fire) w_busy_nxt[alloc_idx] = 1'b1;
    if (flush)        w_busy_nxt            = '0;
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      w_cnt_nxt = w_cnt_nxt + CNT_W'(w_busy_nxt[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regs <= '0;
    end else if (w_wr_eff) begin
      r_regs[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
      if (w_wr_eff && !r_busy[wr_idx]) r_err <= 1'b1;
    end
  end

  assign busy_cnt    = r_cnt;
  assign err_wr_idle = r_err;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    gpr_scoreboard_rdport #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .IDX_W   (IDX_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_rd (
      .i_idx    (rd_idx[p*IDX_W +: IDX_W]),
      .i_regs   (r_regs),
      .i_busy   (r_busy),
      .i_wr_eff (w_wr_eff),
      .i_wr_idx (wr_idx),
      .i_wr_data(wr_data),
      .o_data   (rd_data[p*DATA_W +: DATA_W]),
      .o_busy   (rd_busy[p])
    );
  end
endmodule
